hd_loader: RTL and testbench
============================

HD_LOADER -- requirements
Module: hd_loader

Interface
REQ-001 Parameters: HD_AW, default 32, HD word-address width; IM_AW, default 10, instruction-memory word-address width; IM_DEPTH, default 1024, instruction-memory word count.
REQ-002 clk  in  1  core clock (divided clock from Temporizador); one clock domain, synchronous, active-high reset.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle load request from the control unit; sampled only in IDLE.
REQ-005 abort  in  1  cancels a load in progress.
REQ-006 src_base  in  32  first HD word address (rdata1).
REQ-007 dst_base  in  IM_AW  first instruction-memory word address.
REQ-008 length  in  IM_AW+1  number of words to copy, 0 to IM_DEPTH.
REQ-009 hd_addr  out  32  HD read address.
REQ-010 hd_data  in  32  HD read data, valid one cycle after hd_addr.
REQ-011 im_we  out  1  instruction-memory write strobe.
REQ-012 im_addr  out  IM_AW  instruction-memory write address.
REQ-013 im_data  out  32  instruction-memory write data.
REQ-014 busy  out  1  high while in READ or WRITE.
REQ-015 done  out  1  one-cycle pulse when a load completes successfully.
REQ-016 error  out  1  one-cycle pulse when a load request is rejected.

Function
REQ-017 FSM states: IDLE, READ, WRITE, FINISH, FAULT.
REQ-018 In IDLE, start=1 latches src_base, dst_base and length, and clears the word index i to 0.
REQ-019 From IDLE on start: go to FAULT if dst_base+length > IM_DEPTH (evaluated at IM_AW+2 bits, no wrap); else go to FINISH if length=0; else go to READ.
REQ-020 In READ: hd_addr = src+i (32-bit, wraps modulo 2^32) and im_we=0; next state WRITE.
REQ-021 In WRITE: im_we=1, im_addr=dst+i, im_data=hd_data; i increments by 1; next state FINISH if i=length-1, else READ.
REQ-022 Throughput is one word per 2 cycles; when start is sampled at edge 0, the last write is in cycle 2L and done is high in cycle 2L+1.
REQ-023 FINISH: done=1 for one cycle, then IDLE. FAULT: error=1 for one cycle, then IDLE, with no write issued.
REQ-024 start while not in IDLE is ignored and does not alter the latched parameters.
REQ-025 abort=1 in READ or WRITE returns the block to IDLE on the next edge; a WRITE-cycle write still occurs in that cycle; done is not pulsed.
REQ-026 If abort and start are both high in IDLE, abort wins and the start is dropped.
REQ-027 Outside WRITE, im_we=0; hd_addr holds its last value; im_addr and im_data are don't-care.

Reset
REQ-028 reset, sampled on a clk edge, forces IDLE, i=0, busy=0, done=0, error=0, im_we=0, hd_addr=0, im_addr=0 and im_data=0.
REQ-029 reset has priority over start and abort, including mid-load; an interrupted load produces no done.

Structure
REQ-030 A shared package holds the state enumeration, IM_DEPTH/IM_AW and the HD read latency constant (1).
REQ-031 The block is a single module; no sub-module is required; the index counter is inline.
REQ-032 All outputs are registered except im_we, im_addr and im_data, which decode the current state and registers.

Verification
REQ-033 Basic copy: src=0x20, dst=0x100, length=3, with HD[0x20..0x22]=A,B,C -> writes IM[0x100]=A, IM[0x101]=B, IM[0x102]=C in cycles 2, 4 and 6; done in cycle 7.
REQ-034 Zero length: length=0 -> no im_we; done in cycle 1; busy stays 0.
REQ-035 Overflow: dst=1020, length=5 -> error in cycle 1; no writes. dst=1019, length=5 -> copy accepted; last write to address 1023.
REQ-036 Abort: length=8; abort in cycle 5 -> exactly 2 writes, to dst and dst+1; no done; IDLE in cycle 6.
REQ-037 Busy start: a second start with different parameters in cycle 3 of a 4-word load -> ignored; original destinations written; a single done.
REQ-038 Reset mid-load: reset in cycle 4 -> all outputs are 0 in cycle 5; a new start in cycle 6 works normally.

Source files
------------

// File: rtl/hd_loader_pkg.sv
// Shared definitions for the HD-to-instruction-memory loader.
package hd_loader_pkg;
   localparam int IM_AW_C    = 10;
   localparam int IM_DEPTH_C = 1024;
   localparam int HD_RD_LAT  = 1;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      FINISH,
      FAULT
   } state_t;
endpackage

// File: rtl/hd_loader.sv
// Copies a block of HD words into instruction memory, one word per READ/WRITE pair.
// Range is checked up front; abort or reset stop the copy without a done pulse.
module hd_loader
   import hd_loader_pkg::*;
#(
   parameter int HD_AW    = 32,
   parameter int IM_AW    = IM_AW_C,
   parameter int IM_DEPTH = IM_DEPTH_C
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [HD_AW-1:0] src_base,
   input  logic [IM_AW-1:0] dst_base,
   input  logic [IM_AW:0]   length,
   output logic [HD_AW-1:0] hd_addr,
   input  logic [31:0]      hd_data,
   output logic             im_we,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      im_data,
   output logic             busy,
   output logic             done,
   output logic             error
);
   localparam logic [IM_AW:0]   ONE       = 1;
   localparam logic [IM_AW+1:0] DEPTH_EXT = (IM_AW+2)'(IM_DEPTH);

   state_t           state, nxt;
   logic [HD_AW-1:0] src_q;
   logic [IM_AW-1:0] dst_q;
   logic [IM_AW:0]   len_q;
   logic [IM_AW:0]   idx;
   logic [IM_AW:0]   idx_inc;
   logic [IM_AW+1:0] end_sum;
   logic             range_bad;
   logic             last;

   // The range check runs two bits wider than the address so dst+length cannot wrap.
   assign end_sum   = {2'b00, dst_base} + {1'b0, length};
   assign range_bad = end_sum > DEPTH_EXT;
   assign idx_inc   = idx + ONE;
   assign last      = idx_inc == len_q;

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (range_bad)
                  nxt = FAULT;
               else if (length == '0)
                  nxt = FINISH;
               else
                  nxt = READ;
            end
         end
         READ:    nxt = abort ? IDLE : WRITE;
         WRITE:   nxt = abort ? IDLE : (last ? FINISH : READ);
         FINISH:  nxt = IDLE;
         FAULT:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      im_we   = 1'b0;
      im_addr = '0;
      im_data = '0;
      if (state == WRITE) begin
         im_we   = 1'b1;
         im_addr = dst_q + idx[IM_AW-1:0];
         im_data = hd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx     <= '0;
         hd_addr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state <= nxt;
         busy  <= (nxt == READ) || (nxt == WRITE);
         done  <= nxt == FINISH;
         error <= nxt == FAULT;
         if (state == IDLE && start && !abort) begin
            src_q <= src_base;
            dst_q <= dst_base;
            len_q <= length;
            idx   <= '0;
         end
         if (state == WRITE)
            idx <= idx_inc;
         // The address is registered on entry to READ so the HD data lands in WRITE.
         if (nxt == READ)
            hd_addr <= (state == IDLE) ? src_base : src_q + HD_AW'(idx_inc);
      end
   end
endmodule

// File: tb/tb_hd_loader.sv
// Randomized scoreboard bench for hd_loader against a transaction-level copy model.
module tb_hd_loader;
   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [31:0] src_base;
   logic [9:0]  dst_base;
   logic [10:0] length;
   logic [31:0] hd_addr, hd_data;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [31:0] im_data;
   logic        busy, done, error;

   hd_loader dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .src_base(src_base), .dst_base(dst_base), .length(length),
      .hd_addr(hd_addr), .hd_data(hd_data),
      .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [9:0]  addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   ev_t exp_q[$];
   bit  exp_busy[int];
   int  errors = 0;
   int  checks = 0;
   int  cnt = 0;
   bit  mon_en = 1'b0;

   function automatic logic [31:0] hd_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   always @(posedge clk) cnt <= cnt + 1;
   always @(posedge clk) hd_data <= hd_fn(hd_addr);

   task automatic check_ev(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%h data=%h, required none", kind, cnt, im_addr, im_data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cnt || (kind == 0 && (e.addr !== im_addr || e.data !== im_data))) begin
            errors++;
            $display("FAIL event actual kind=%0d cyc=%0d addr=%h data=%h, required kind=%0d cyc=%0d addr=%h data=%h",
                     kind, cnt, im_addr, im_data, e.kind, e.cyc, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (busy !== exp_busy.exists(cnt)) begin
            errors++;
            $display("FAIL busy cyc=%0d actual=%b required=%b", cnt, busy, exp_busy.exists(cnt));
         end
         if (im_we === 1'b1) check_ev(0);
         if (done  === 1'b1) check_ev(1);
         if (error === 1'b1) check_ev(2);
      end
   end

   task automatic check_zero(input string name);
      checks++;
      if ({busy, done, error, im_we} !== 4'b0 || hd_addr !== '0 || im_addr !== '0 || im_data !== '0) begin
         errors++;
         $display("FAIL %s outputs busy=%b done=%b error=%b we=%b hd_addr=%h im_addr=%h im_data=%h, required all 0",
                  name, busy, done, error, im_we, hd_addr, im_addr, im_data);
      end
   endtask

   // Expected outcome of one load from its parameters and the cycle it is cut short (0 = never).
   task automatic model(input logic [31:0] src, input logic [9:0] dst, input int len,
                        input int ac, input int rc, input int e0);
      int stop;
      ev_t e;
      stop = 1000000;
      if (ac != 0 && ac < stop) stop = ac;
      if (rc != 0 && rc < stop) stop = rc;
      if (int'(dst) + len > 1024) begin
         e = '{2, 10'd0, 32'd0, e0};
         exp_q.push_back(e);
      end else if (len == 0) begin
         e = '{1, 10'd0, 32'd0, e0};
         exp_q.push_back(e);
      end else begin
         for (int c = 1; c <= 2 * len && c <= stop; c++) exp_busy[e0 + c - 1] = 1'b1;
         for (int j = 0; j < len; j++) begin
            if (2 * j + 2 <= stop) begin
               e = '{0, 10'(int'(dst) + j), hd_fn(src + 32'(j)), e0 + 2 * j + 1};
               exp_q.push_back(e);
            end
         end
         if (stop >= 2 * len + 1) begin
            e = '{1, 10'd0, 32'd0, e0 + 2 * len};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_load(input logic [31:0] src, input logic [9:0] dst, input int len,
                           input int ac, input int rc, input int ss);
      int e0, ncyc;
      @(posedge clk); #1;
      src_base = src; dst_base = dst; length = 11'(len);
      start = 1'b1;
      e0 = cnt + 1;
      model(src, dst, len, ac, rc, e0);
      ncyc = (len == 0 || int'(dst) + len > 1024) ? 3 : 2 * len + 3;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk); #1;
         start = (k == ss);
         if (k == ss) begin
            src_base = ~src; dst_base = dst + 10'd7; length = 11'($urandom_range(1, 9));
         end
         abort = (k == ac);
         reset = (k == rc);
         if (rc != 0 && k == rc + 1) begin
            @(negedge clk);
            check_zero("after_reset");
            break;
         end
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0;
   endtask

   initial begin
      int len, ac, rc, ss, lim;
      logic [9:0]  dst;
      logic [31:0] src;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      src_base = '0; dst_base = '0; length = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_state");
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;

      run_load(32'h20, 10'h100, 3, 0, 0, 0);
      run_load(32'h40, 10'd5, 0, 0, 0, 0);
      run_load(32'h60, 10'd1020, 5, 0, 0, 0);
      run_load(32'h60, 10'd1019, 5, 0, 0, 0);
      run_load(32'h80, 10'h040, 8, 5, 0, 0);
      run_load(32'h90, 10'h080, 6, 4, 0, 0);
      run_load(32'hA0, 10'h200, 4, 0, 0, 3);
      run_load(32'hB0, 10'h300, 6, 0, 4, 0);
      run_load(32'hC0, 10'h010, 2, 0, 0, 0);
      run_load(32'hFFFF_FFFE, 10'h000, 4, 0, 0, 0);
      run_load(32'h1234, 10'd0, 1024, 0, 0, 0);
      run_load(32'h55, 10'd0, 1025, 0, 0, 0);

      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; src_base = 32'h77; dst_base = 10'h20; length = 11'd3;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      repeat (4) @(posedge clk);

      for (int t = 0; t < 40; t++) begin
         len = $urandom_range(0, 12);
         dst = ($urandom_range(0, 1) == 1) ? 10'(1024 - $urandom_range(1, 14)) : 10'($urandom);
         src = $urandom;
         ac = 0; rc = 0; ss = 0;
         if (len != 0 && int'(dst) + len <= 1024) begin
            if ($urandom_range(0, 3) == 0) ac = $urandom_range(1, 2 * len);
            else if ($urandom_range(0, 7) == 0) rc = $urandom_range(1, 2 * len);
            lim = 2 * len;
            if (ac != 0) lim = ac;
            if (rc != 0) lim = rc;
            if ($urandom_range(0, 3) == 0) ss = $urandom_range(1, lim);
         end
         run_load(src, dst, len, ac, rc, ss);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events actual=0 seen, required %0d more", exp_q.size());
      end
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
